// File: rtl/pc_fetch_unit.sv
// Instruction-fetch / next-PC stage for the single-cycle MIPS datapath.
// It fetches over a req/ready handshake, holds Instr for one EXEC cycle, and then advances the PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int unsigned IMEM_AW  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        Instr,
    output logic               instr_valid,
    input  logic               Jump,
    input  logic               Branch,
    input  logic               RegToPC,
    input  logic               Zero,
    input  logic [31:0]        Imm,
    input  logic [25:0]        JTarget,
    input  logic [31:0]        RegData,
    output logic [31:0]        PC,
    output logic [31:0]        PCPlus4,
    output logic               misalign
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic        req_next;
    logic        valid_next;
    logic        misalign_next;
    logic [31:0] instr_next;
    logic [31:0] pc_next;
    logic [31:0] next_pc;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign PCPlus4       = PC + 32'd4;
    assign branch_target = PCPlus4 + (Imm << 2);
    assign jump_target   = {PCPlus4[31:28], JTarget, 2'b00};
    assign imem_addr     = PC[IMEM_AW-1:0];

    // jr also raises Jump, so RegToPC has to be tested first.
    always_comb begin
        if (RegToPC) begin
            next_pc = RegData;
        end else if (Jump) begin
            next_pc = jump_target;
        end else if (Branch && Zero) begin
            next_pc = branch_target;
        end else begin
            next_pc = PCPlus4;
        end
    end

    // NOTE: every signal gets a default before the case statement, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        req_next      = 1'b0;
        valid_next    = 1'b0;
        instr_next    = Instr;
        pc_next       = PC;
        misalign_next = misalign;
        unique case (state)
            FETCH: begin
                if (!hold) begin
                    req_next   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // The request is never withdrawn while waiting, and hold is not looked at here.
                req_next = 1'b1;
                if (imem_ready) begin
                    instr_next = imem_rdata;
                    req_next   = 1'b0;
                    valid_next = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (next_pc[1:0] != 2'b00) begin
                    misalign_next = 1'b1;
                    state_next    = HALT;
                end else begin
                    pc_next    = next_pc;
                    state_next = FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples its value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            Instr       <= 32'h00000000;
            PC          <= RESET_PC;
            misalign    <= 1'b0;
        end else begin
            state       <= state_next;
            imem_req    <= req_next;
            instr_valid <= valid_next;
            Instr       <= instr_next;
            PC          <= pc_next;
            misalign    <= misalign_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit.
// It runs a table of fetch/execute vectors, then hand-written sequences for halt, hold and reset.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        Jump;
    logic        Branch;
    logic        RegToPC;
    logic        Zero;
    logic [31:0] Imm;
    logic [25:0] JTarget;
    logic [31:0] RegData;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        misalign;

    pc_fetch_unit #(.RESET_PC(32'h00000000), .IMEM_AW(32)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .Instr(Instr), .instr_valid(instr_valid),
        .Jump(Jump), .Branch(Branch), .RegToPC(RegToPC), .Zero(Zero),
        .Imm(Imm), .JTarget(JTarget), .RegData(RegData),
        .PC(PC), .PCPlus4(PCPlus4), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          latency;
        logic        hold_in_wait;
        logic [31:0] rdata;
        logic        jump;
        logic        branch;
        logic        reg_to_pc;
        logic        zero;
        logic [31:0] imm;
        logic [25:0] jtarget;
        logic [31:0] reg_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[14];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The monitor pops one scoreboard entry for every EXEC cycle the DUT shows.
    always @(negedge clk) begin
        if (!rst && instr_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_valid: instr_valid=1 at PC 0x%08h, expected no EXEC", PC);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_instr", Instr, e.instr);
                check("sb_pc", PC, e.pc);
                check("sb_pcplus4", PCPlus4, e.pc + 32'd4);
            end
        end
    end

    task automatic clear_ctrl();
        Jump = 1'b0; Branch = 1'b0; RegToPC = 1'b0; Zero = 1'b0;
        Imm = 32'h0; JTarget = 26'h0; RegData = 32'h0;
    endtask

    // Entered just after an edge with the DUT in FETCH. Runs one fetch plus its EXEC cycle.
    task automatic run_vec(input vec_t v);
        sb_t e;
        check("fetch_req_idle", {31'b0, imem_req}, 32'd0);
        hold = 1'b0;
        e.instr = v.rdata;
        e.pc    = v.exp_pc;
        sb_q.push_back(e);
        step();
        check("wait_req", {31'b0, imem_req}, 32'd1);
        check("wait_addr", imem_addr, v.exp_pc);
        for (int k = 0; k < v.latency; k++) begin
            hold       = v.hold_in_wait;
            imem_ready = 1'b0;
            step();
            check("wait_req_held", {31'b0, imem_req}, 32'd1);
            check("wait_addr_stable", imem_addr, v.exp_pc);
            check("wait_no_valid", {31'b0, instr_valid}, 32'd0);
        end
        hold       = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = v.rdata;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        check("exec_valid", {31'b0, instr_valid}, 32'd1);
        check("exec_req_low", {31'b0, imem_req}, 32'd0);
        Jump = v.jump; Branch = v.branch; RegToPC = v.reg_to_pc; Zero = v.zero;
        Imm = v.imm; JTarget = v.jtarget; RegData = v.reg_data;
        step();
        clear_ctrl();
        check("next_pc", PC, v.exp_next);
        check("misalign", {31'b0, misalign}, {31'b0, v.exp_mis});
        check("post_exec_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    function automatic vec_t mk(input int lat, input logic hw, input logic [31:0] rd,
                                input logic j, input logic b, input logic r, input logic z,
                                input logic [31:0] imm, input logic [25:0] jt, input logic [31:0] rdat,
                                input logic [31:0] pc, input logic [31:0] nxt, input logic mis);
        vec_t v;
        v.latency = lat; v.hold_in_wait = hw; v.rdata = rd;
        v.jump = j; v.branch = b; v.reg_to_pc = r; v.zero = z;
        v.imm = imm; v.jtarget = jt; v.reg_data = rdat;
        v.exp_pc = pc; v.exp_next = nxt; v.exp_mis = mis;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 32'h11110000, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0,        32'h00000000, 32'h00000004, 0);
        vecs[1]  = mk(0, 0, 32'h11110001, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0,        32'h00000004, 32'h00000008, 0);
        vecs[2]  = mk(0, 0, 32'h11110002, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0,        32'h00000008, 32'h0000000C, 0);
        vecs[3]  = mk(4, 1, 32'h22220003, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0,        32'h0000000C, 32'h00000010, 0);
        vecs[4]  = mk(1, 0, 32'h10000004, 0, 1, 0, 1, 32'hFFFFFFFE, 26'h0,       32'h0,        32'h00000010, 32'h0000000C, 0);
        vecs[5]  = mk(0, 0, 32'h33330005, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0,        32'h0000000C, 32'h00000010, 0);
        vecs[6]  = mk(2, 0, 32'h10000006, 0, 1, 0, 0, 32'hFFFFFFFE, 26'h0,       32'h0,        32'h00000010, 32'h00000014, 0);
        vecs[7]  = mk(0, 0, 32'h00000008, 1, 0, 1, 0, 32'h0,        26'h0,       32'h40000010, 32'h00000014, 32'h40000010, 0);
        vecs[8]  = mk(0, 0, 32'h08000100, 1, 0, 0, 0, 32'h0,        26'h0000100, 32'h0,        32'h40000010, 32'h40000400, 0);
        vecs[9]  = mk(1, 0, 32'h08000020, 1, 1, 0, 1, 32'h00000001, 26'h0000020, 32'h0,        32'h40000400, 32'h40000080, 0);
        vecs[10] = mk(0, 0, 32'h00000208, 1, 0, 1, 0, 32'h0,        26'h0000003, 32'h00000200, 32'h40000080, 32'h00000200, 0);
        vecs[11] = mk(0, 0, 32'h00000308, 1, 0, 1, 0, 32'h0,        26'h0,       32'hFFFFFFFC, 32'h00000200, 32'hFFFFFFFC, 0);
        vecs[12] = mk(3, 0, 32'h44440012, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0,        32'hFFFFFFFC, 32'h00000000, 0);
        vecs[13] = mk(0, 0, 32'h00000408, 1, 0, 1, 0, 32'h0,        26'h0,       32'h00000202, 32'h00000000, 32'h00000000, 1);

        rst = 1'b1; hold = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        clear_ctrl();
        step();
        step();
        rst = 1'b0;
        check("rst_pc", PC, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_pcplus4", PCPlus4, 32'h4);

        foreach (vecs[i]) run_vec(vecs[i]);

        // HALT: no new requests or EXEC cycles, even with a stray ready pulse.
        for (int k = 0; k < 4; k++) begin
            imem_ready = (k == 1);
            imem_rdata = 32'hBADBAD00;
            step();
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_valid", {31'b0, instr_valid}, 32'd0);
            check("halt_misalign", {31'b0, misalign}, 32'd1);
            check("halt_pc", PC, 32'h0);
        end
        imem_ready = 1'b0;

        // Reset clears the halt, and hold keeps FETCH idle.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        hold = 1'b1;
        check("unhalt_misalign", {31'b0, misalign}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_no_req", {31'b0, imem_req}, 32'd0);
        end

        // Reset arrives in the middle of WAIT, then a stale ready comes one cycle later.
        hold = 1'b0;
        step();
        check("midwait_req", {31'b0, imem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midwait_rst_req", {31'b0, imem_req}, 32'd0);
        check("midwait_rst_pc", PC, 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        imem_ready = 1'b0;
        check("stale_ready_instr", Instr, 32'h0);
        check("stale_ready_valid", {31'b0, instr_valid}, 32'd0);
        check("refetch_req", {31'b0, imem_req}, 32'd1);

        // Recover with a normal fetch from RESET_PC.
        begin
            sb_t e;
            e.instr = 32'hCAFE0001;
            e.pc    = 32'h0;
            sb_q.push_back(e);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE0001;
        step();
        imem_ready = 1'b0;
        check("recover_valid", {31'b0, instr_valid}, 32'd1);
        step();
        check("recover_next_pc", PC, 32'h4);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
